// File: rtl/seg7_pkg.sv
// Shared constants for the BCD counter display: segment codes (active-low {g..a}),
// anode-off level and BCD digit width.
package seg7_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic ANO_OFF = 1'b1;

    // BCD digit to active-low segment pattern; non-decimal codes blank the digit
    function automatic logic [6:0] seg7(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Button conditioner: 2-flop synchroniser, stability counter, and a one-cycle pulse
// on each accepted rising edge.
module debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync0;
    logic          sync1;
    logic          samp;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          accept_c;

    assign accept_c = (sync1 == samp) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // A press only counts once the button has been seen stably released after
    // reset, so a button held through reset release never fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            samp  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            armed <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            pulse <= 1'b0;
            if (sync1 != samp) begin
                samp <= sync1;
                cnt  <= '0;
            end else if (!accept_c) begin
                cnt <= cnt + CW'(1);
            end else begin
                level <= samp;
                if (!samp) begin
                    armed <= 1'b1;
                end
                pulse <= samp & ~level & armed;
            end
        end
    end

endmodule

// File: rtl/syn_sub_counter_display.sv
// BCD down counter with load, driven by debounced buttons, shown on a multiplexed
// active-low 7-segment display.
module syn_sub_counter_display
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SCAN_DIV        = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btnd,
    input  logic                      btnl,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    output logic [6:0]                leds,
    output logic [DIGITS-1:0]         ano,
    output logic                      zero,
    output logic                      borrow
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic                         dec_p;
    logic                         load_p;
    logic                         dec_level_unused;
    logic                         load_level_unused;
    logic [DIGITS-1:0][BCD_W-1:0] count;
    logic [DIGITS-1:0][BCD_W-1:0] count_n;
    logic                         borrow_n;
    logic [DW-1:0]                div;
    logic [IW-1:0]                index;

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk   (clk),
        .reset (reset),
        .raw   (btnd),
        .level (dec_level_unused),
        .pulse (dec_p)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk   (clk),
        .reset (reset),
        .raw   (btnl),
        .level (load_level_unused),
        .pulse (load_p)
    );

    // Next count: clamped load has priority over ripple-borrow decrement
    always_comb begin
        logic             bin;
        logic [BCD_W-1:0] ld;
        count_n  = count;
        borrow_n = 1'b0;
        bin      = 1'b1;
        ld       = '0;
        if (load_p) begin
            for (int i = 0; i < DIGITS; i++) begin
                ld         = load_val[i*BCD_W +: BCD_W];
                count_n[i] = (ld > BCD_W'(9)) ? BCD_W'(9) : ld;
            end
        end else if (dec_p) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (bin) begin
                    if (count[i] == '0) begin
                        count_n[i] = BCD_W'(9);
                    end else begin
                        count_n[i] = count[i] - BCD_W'(1);
                        bin        = 1'b0;
                    end
                end
            end
            borrow_n = bin;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            zero   <= 1'b1;
            borrow <= 1'b0;
        end else begin
            count  <= count_n;
            zero   <= (count_n == '0);
            borrow <= borrow_n;
        end
    end

    // Digit scan: advance one anode per SCAN_DIV cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div   <= '0;
            index <= '0;
        end else if (div == DW'(SCAN_DIV - 1)) begin
            div   <= '0;
            index <= (index == IW'(DIGITS - 1)) ? '0 : index + IW'(1);
        end else begin
            div <= div + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ano  <= {DIGITS{ANO_OFF}} ^ DIGITS'(1);
            leds <= SEG_0;
        end else begin
            ano  <= {DIGITS{ANO_OFF}} ^ (DIGITS'(1) << index);
            leds <= seg7(count[index]);
        end
    end

endmodule
